// File: rtl/psum_drain_reader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | psum_drain_reader: streams a contiguous psum RAM range downstream over    |
// | valid/ready with a 2-entry skid FIFO and credit-based read issue.         |
// | Optional macro: PSUM_DRAIN_RELU_EN (clamp negative lanes to 0 at push).   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module psum_drain_reader #(
   parameter int ARRAY_DIM  = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start_i,
   input  logic [ADDR_WIDTH-1:0]          base_addr_i,
   input  logic [ADDR_WIDTH:0]            num_words_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           ren_o,
   output logic [ADDR_WIDTH-1:0]          raddr_o,
   input  logic [ARRAY_DIM*ACC_WIDTH-1:0] rdata_i,
   output logic                           m_valid_o,
   input  logic                           m_ready_i,
   output logic [ARRAY_DIM*ACC_WIDTH-1:0] m_data_o,
   output logic                           m_last_o
);

   localparam int                DW  = ARRAY_DIM * ACC_WIDTH;
   localparam logic [ADDR_WIDTH:0] ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   num_q, num_d;
   logic [ADDR_WIDTH:0]   issued_q, issued_d;
   logic [ADDR_WIDTH:0]   popped_q, popped_d;
   logic                  inflight_q;
   logic [1:0]            count_q;
   logic                  rd_ptr_q, wr_ptr_q;
   logic [DW-1:0]         mem_q [2];

   logic [DW-1:0]         push_data;
   logic                  push, pop, ren;
   logic [2:0]            credit;

`ifdef PSUM_DRAIN_RELU_EN
   for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_relu
      assign push_data[i*ACC_WIDTH +: ACC_WIDTH] =
         rdata_i[(i+1)*ACC_WIDTH-1] ? '0 : rdata_i[i*ACC_WIDTH +: ACC_WIDTH];
   end
`else
   assign push_data = rdata_i;
`endif

   assign m_valid_o = (count_q != 2'd0);
   assign m_data_o  = mem_q[rd_ptr_q];
   assign m_last_o  = m_valid_o && (popped_q == (num_q - ONE));
   assign busy_o    = (state_q == S_READ) || (state_q == S_FLUSH);
   assign done_o    = (state_q == S_DONE);
   assign ren_o     = ren;
   assign raddr_o   = base_q + issued_q[ADDR_WIDTH-1:0];
   assign push      = inflight_q;
   assign pop       = m_valid_o & m_ready_i;
   // Occupancy after this edge if no new read were issued; must stay below 2 to issue.
   assign credit    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      num_d    = num_q;
      issued_d = issued_q;
      popped_d = pop ? (popped_q + ONE) : popped_q;
      ren      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (num_words_i == '0) begin
                  state_d = S_DONE;
               end else begin
                  base_d   = base_addr_i;
                  num_d    = num_words_i;
                  issued_d = '0;
                  popped_d = '0;
                  state_d  = S_READ;
               end
            end
         end
         S_READ: begin
            if (credit < 3'd2) begin
               ren      = 1'b1;
               issued_d = issued_q + ONE;
               if (issued_d == num_q) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (!inflight_q && (credit == 3'd0)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         num_q      <= num_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         inflight_q <= ren;
         count_q    <= count_q + {1'b0, push} - {1'b0, pop};
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count_q == 2'd2)));

endmodule
`default_nettype wire

// File: tb/tb_psum_drain_reader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_psum_drain_reader: randomized drains checked against a RAM-image model.|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_psum_drain_reader;

   localparam int LANES = 16;
   localparam int ACCW  = 32;
   localparam int AW    = 10;
   localparam int DW    = LANES * ACCW;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   num_words = '0;
   logic          busy, done, ren;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;

   logic [DW-1:0] ram [DEPTH];
   int            vecs = 0;
   int            errs = 0;

   psum_drain_reader #(.ARRAY_DIM(LANES), .ACC_WIDTH(ACCW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base_addr),
      .num_words_i(num_words), .busy_o(busy), .done_o(done), .ren_o(ren),
      .raddr_o(raddr), .rdata_i(rdata), .m_valid_o(m_valid), .m_ready_i(m_ready),
      .m_data_o(m_data), .m_last_o(m_last)
   );

   always #5 clk = ~clk;

   // Psum RAM with 1-cycle read latency
   always @(posedge clk) if (ren) rdata <= ram[raddr];

   function automatic logic [DW-1:0] exp_word(input int a);
      logic [DW-1:0] w;
      w = ram[a % DEPTH];
`ifdef PSUM_DRAIN_RELU_EN
      for (int l = 0; l < LANES; l++)
         if (w[l*ACCW + ACCW - 1]) w[l*ACCW +: ACCW] = '0;
`endif
      return w;
   endfunction

   task automatic fill_random();
      for (int a = 0; a < DEPTH; a++)
         for (int l = 0; l < LANES; l++) ram[a][l*ACCW +: ACCW] = $urandom;
   endtask

   // mode 0: always ready, 1: ready every third cycle, 2: random ready
   task automatic run_drain(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                            input bit timing, input bit restart);
      int            cyc, idx, nren, limit;
      bit            done_seen, stall, exp_last;
      logic [DW-1:0] prev;
      logic [AW-1:0] exp_addr;
      @(negedge clk);
      start = 1'b1; base_addr = b; num_words = n;
      @(negedge clk);
      start = 1'b0; base_addr = AW'($urandom); num_words = (AW+1)'($urandom);
      cyc = 1; idx = 0; nren = 0; done_seen = 0; stall = 0; prev = '0;
      limit = 100 + 4 * int'(n);
      while (!done_seen && cyc < limit) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            default: m_ready = ($urandom_range(3, 0) != 0);
         endcase
         start = restart && (cyc == 5);
         #1;
         if (ren) begin
            vecs++;
            exp_addr = AW'((int'(b) + nren) % DEPTH);
            if (raddr !== exp_addr || nren >= int'(n)) begin
               errs++;
               $display("FAIL raddr cyc=%0d got=%0d want=%0d reads=%0d", cyc, raddr, exp_addr, nren);
            end
            nren++;
         end
         if (stall) begin
            vecs++;
            if (m_valid !== 1'b1 || m_data !== prev) begin
               errs++;
               $display("FAIL stall_hold cyc=%0d valid=%b data_changed=%b", cyc, m_valid, m_data !== prev);
            end
         end
         if (m_valid === 1'b1) begin
            vecs++;
            exp_last = (idx == int'(n) - 1);
            if (idx >= int'(n) || m_data !== exp_word(int'(b) + idx) || m_last !== exp_last) begin
               errs++;
               $display("FAIL word idx=%0d got=%h last=%b want=%h last=%b", idx, m_data[63:0], m_last,
                        exp_word(int'(b) + idx) >> 0 & 64'hFFFFFFFFFFFFFFFF, exp_last);
            end
            if (m_ready) idx++;
         end
         stall = (m_valid === 1'b1) && !m_ready;
         prev  = m_data;
         vecs++;
         if (nren - idx > 2 || busy !== ((n != 0) && !done)) begin
            errs++;
            $display("FAIL occupancy_busy cyc=%0d outstanding=%0d busy=%b", cyc, nren - idx, busy);
         end
         if (timing) begin
            vecs++;
            if (ren !== (cyc <= int'(n)) || m_valid !== (cyc >= 3 && cyc <= int'(n) + 2) ||
                done !== (cyc == ((n == 0) ? 1 : int'(n) + 3))) begin
               errs++;
               $display("FAIL timing cyc=%0d ren=%b valid=%b done=%b n=%0d", cyc, ren, m_valid, done, n);
            end
         end
         if (done === 1'b1) begin
            done_seen = 1;
            vecs++;
            if (idx != int'(n) || nren != int'(n)) begin
               errs++;
               $display("FAIL completion got_words=%0d reads=%0d want=%0d", idx, nren, n);
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      vecs++;
      if (!done_seen) begin
         errs++;
         $display("FAIL timeout no done within %0d cycles (n=%0d)", limit, n);
      end
      #1;
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0 || ren !== 1'b0 || m_valid !== 1'b0) begin
         errs++;
         $display("FAIL post_done done=%b busy=%b ren=%b valid=%b want 0", done, busy, ren, m_valid);
      end
   endtask

   task automatic test_reset();
      #1;
      vecs++;
      if (busy !== 0 || done !== 0 || ren !== 0 || raddr !== '0 || m_valid !== 0 ||
          m_data !== '0 || m_last !== 0) begin
         errs++;
         $display("FAIL reset_outputs busy=%b done=%b ren=%b raddr=%0d valid=%b last=%b want all 0",
                  busy, done, ren, raddr, m_valid, m_last);
      end
   endtask

   task automatic test_basic();
      for (int a = 0; a < 4; a++)
         for (int l = 0; l < LANES; l++) ram[a][l*ACCW +: ACCW] = ACCW'(a + 1);
      run_drain(10'd0, 11'd4, 0, 1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      fill_random();
      run_drain(10'd1022, 11'd4, 0, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      run_drain(AW'($urandom), 11'd8, 1, 1'b0, 1'b0);
      for (int t = 0; t < 6; t++)
         run_drain(AW'($urandom), (AW+1)'($urandom_range(40, 1)), 2, 1'b0, 1'b0);
      run_drain(AW'($urandom), 11'd1024, 2, 1'b0, 1'b0);
   endtask

   task automatic test_zero();
      run_drain(AW'($urandom), 11'd0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_restart_ignored();
      run_drain(AW'($urandom), 11'd16, 0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid();
      bit bad = 0;
      @(negedge clk);
      start = 1'b1; base_addr = AW'($urandom); num_words = 11'd16; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vecs++;
      if (busy !== 0 || done !== 0 || ren !== 0 || raddr !== '0 || m_valid !== 0 ||
          m_data !== '0 || m_last !== 0) begin
         errs++;
         $display("FAIL mid_reset_outputs busy=%b done=%b ren=%b raddr=%0d valid=%b want all 0",
                  busy, done, ren, raddr, m_valid);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         #1;
         if (done !== 0 || busy !== 0 || m_valid !== 0 || ren !== 0) bad = 1;
      end
      vecs++;
      if (bad) begin
         errs++;
         $display("FAIL abort_quiet activity after mid-drain reset got=1 want=0");
      end
      run_drain(AW'($urandom), 11'd16, 2, 1'b0, 1'b0);
   endtask

   task automatic test_relu_values();
      int            cyc = 0;
      logic [ACCW-1:0] want_neg;
      for (int l = 0; l < LANES; l++)
         ram[100][l*ACCW +: ACCW] = (l % 2 == 0) ? 32'hFFFF_FFF6 : 32'h0000_0007;
`ifdef PSUM_DRAIN_RELU_EN
      want_neg = 32'h0;
`else
      want_neg = 32'hFFFF_FFF6;
`endif
      @(negedge clk);
      start = 1'b1; base_addr = 10'd100; num_words = 11'd1; m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (m_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      #1;
      vecs++;
      if (m_valid !== 1'b1 || m_data[31:0] !== want_neg || m_data[63:32] !== 32'h7) begin
         errs++;
         $display("FAIL relu_lanes valid=%b lane0=%h lane1=%h want %h %h", m_valid,
                  m_data[31:0], m_data[63:32], want_neg, 32'h7);
      end
      m_ready = 1'b1;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin @(negedge clk); #1; cyc++; end
      vecs++;
      if (done !== 1'b1) begin
         errs++;
         $display("FAIL relu_done got=0 want=1");
      end
      @(negedge clk);
   endtask

   initial begin
      fill_random();
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero();
      test_restart_ignored();
      test_reset_mid();
      test_relu_values();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/psum_drain_reader.md
Name: psum_drain_reader

Overview:
Read side of the partial-sum buffer. After accumulation over all kernels completes, the controller issues a drain command. The block reads a contiguous range of psum words from the psum RAM, which has 1-cycle read latency. It streams each word downstream over a valid/ready interface to the output/requant stage, with full backpressure and no data loss. The block shares the psum RAM address space with the accumulator write path; the controller guarantees no accumulation is active while a drain is running.

Parameters:
ARRAY_DIM, 16, lanes per psum word
ACC_WIDTH, 32, bits per lane accumulator
ADDR_WIDTH, 10, psum RAM address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  drain command pulse; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first word address, captured on start
num_words  in  ADDR_WIDTH+1  words to drain, captured on start; range 0..2^ADDR_WIDTH
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
ren  out  1  RAM read enable
raddr  out  ADDR_WIDTH  RAM read address
rdata  in  ARRAY_DIM*ACC_WIDTH  RAM read data, valid the cycle after ren
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  ARRAY_DIM*ACC_WIDTH  output psum word, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
m_last  out  1  high with the final word of a drain

Behaviour:
- Reset: async, active-low. All outputs reset to 0 (busy, done, ren, raddr, m_valid, m_data, m_last). FSM resets to IDLE, output buffer is emptied, in-flight read is discarded. Reset mid-drain aborts the drain with no done pulse.
- FSM states: IDLE, READ, FLUSH, DONE.
  - IDLE, start=1, num_words>0: capture inputs, go to READ.
  - IDLE, start=1, num_words=0: go to DONE; no reads issued, no output words.
  - READ -> FLUSH when the last read has been issued.
  - FLUSH -> DONE when the buffer is empty and no read is in flight (the final word has handshaked).
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored in every state except IDLE.
- Read issue: ren=1 in READ only when (buf_count + inflight - pop) < 2.
  - buf_count: 0..2, entries in a 2-entry output FIFO.
  - inflight: 1 if ren was high in the previous cycle.
  - pop = m_valid & m_ready.
  - raddr = base_addr + issued_count, modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH-1 to 0).
- Capture: rdata is pushed into the FIFO on the edge ending the cycle after ren. A push and a pop in the same cycle keeps buf_count unchanged. Overflow is impossible by the credit rule; an assertion checks it.
- Latency: start sampled at edge E0 -> ren with raddr=base_addr in cycle 1 -> rdata in cycle 2 -> m_valid=1 in cycle 3. With m_ready held high, throughput is 1 word/cycle and N words occupy cycles 3..N+2; done pulses in cycle N+3 and busy drops in the same cycle.
- Handshake: once m_valid=1, m_valid, m_data and m_last hold until m_ready=1. Words are delivered in address order with none dropped or duplicated. m_last=1 only on the word whose sequence index is num_words-1.
- Arithmetic: issued_count and popped_count are ADDR_WIDTH+1 bits wide, so num_words=2^ADDR_WIDTH drains the full RAM.

Optional Feature:
PSUM_DRAIN_RELU_EN
- Defined: each lane of m_data is a signed ACC_WIDTH value, clamped to 0 if negative. The clamp is applied at FIFO push, so latency is unchanged.
- Undefined: m_data is rdata passed through bit-exact.

Test Plan:
- base=0, num=4, RAM[i]=i+1 in every lane, m_ready=1 -> m_data 1,2,3,4 in cycles 3..6; m_last in cycle 6; done in cycle 7; ren high in cycles 1..4 only.
- base=1022, num=4, ADDR_WIDTH=10 -> raddr sequence 1022, 1023, 0, 1; output order matches.
- num=8 with m_ready toggling 1,0,0,1,... -> all 8 words in order; m_data stable while stalled; buf_count never exceeds 2.
- num=0 -> done in cycle 1; no ren and no m_valid ever.
- start pulsed again mid-drain -> ignored; asserting rst_n=0 in cycle 5 of num=16 -> all outputs 0 immediately, no done; a fresh start afterwards drains correctly.
- RELU build: lane value 0xFFFFFFF6 (-10) -> 0; lane value 0x00000007 -> 7. Non-RELU build: both values pass through unchanged.
